// File: rtl/board_mem_arbiter.sv
// Two-port arbiter and burst sequencer for the single-ported board Memory: render (read-only, high priority) and game (read/write).
// Optional row guard under BOARD_ROW_GUARD_EN: invalid rows run full timing with writes suppressed and reads returned as 0.
//
// state | meaning
// IDLE  | no burst; a request is arbitrated and granted combinationally (mem_start)
// BURST | COLS beats for the registered owner, mem_cont high, counter = beat column
module board_mem_arbiter #(
    parameter int COLS  = 10,
    parameter int ROW_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ren_req,
    input  logic [ROW_W-1:0] ren_row,
    output logic             ren_gnt,
    output logic             ren_beat,
    output logic             ren_last,
    input  logic             gm_req,
    input  logic [ROW_W-1:0] gm_row,
    input  logic             gm_we,
    input  logic [2:0]       gm_wdata,
    output logic             gm_gnt,
    output logic             gm_beat,
    output logic             gm_last,
    output logic             gm_err,
    output logic [2:0]       rd_data,
    output logic [3:0]       beat_col,
    output logic             busy,
    output logic             mem_start,
    output logic             mem_write_enable,
    output logic             mem_cont,
    output logic [ROW_W-1:0] mem_addr,
    output logic [2:0]       mem_wdata,
    input  logic [2:0]       mem_rdata
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam logic [3:0] LAST_BEAT = 4'(COLS - 1);

    logic [0:0]       state;
    logic             own_gm;
    logic [ROW_W-1:0] row_q;
    logic             we_q;
    logic [3:0]       cnt;

    logic             any_req;
    logic [ROW_W-1:0] sel_row;
    logic             sel_we;
    logic             sel_bad;
    logic             bad_q;

    assign any_req = ren_req | gm_req;
    assign sel_row = ren_req ? ren_row : gm_row;
    assign sel_we  = ~ren_req & gm_we;

`ifdef BOARD_ROW_GUARD_EN
    function automatic logic row_bad(input logic [ROW_W-1:0] r);
        int ri;
        ri = int'(r);
        return ((ri >= 20) && (ri <= 31)) || ((ri >= 52) && (ri <= 63));
    endfunction

    assign sel_bad = row_bad(sel_row);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_q <= 1'b0;
        end else if ((state == ST_IDLE) && any_req) begin
            bad_q <= sel_bad;
        end
    end
`else
    assign sel_bad = 1'b0;
    assign bad_q   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            own_gm <= 1'b0;
            row_q  <= '0;
            we_q   <= 1'b0;
            cnt    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state  <= ST_BURST;
                        own_gm <= ~ren_req;
                        row_q  <= sel_row;
                        we_q   <= sel_we;
                        cnt    <= 4'd0;
                    end
                end
                default: begin
                    if (cnt == LAST_BEAT) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    // Outputs are gated by reset_n so they drop to 0 asynchronously, even with requests pending.
    always_comb begin
        ren_gnt          = 1'b0;
        ren_beat         = 1'b0;
        ren_last         = 1'b0;
        gm_gnt           = 1'b0;
        gm_beat          = 1'b0;
        gm_last          = 1'b0;
        gm_err           = 1'b0;
        rd_data          = 3'd0;
        beat_col         = 4'd0;
        busy             = 1'b0;
        mem_start        = 1'b0;
        mem_write_enable = 1'b0;
        mem_cont         = 1'b0;
        mem_addr         = '0;
        mem_wdata        = 3'd0;
        if (reset_n) begin
            if (state == ST_IDLE) begin
                if (any_req) begin
                    mem_start        = 1'b1;
                    mem_addr         = sel_row;
                    mem_write_enable = sel_we & ~sel_bad;
                    ren_gnt          = ren_req;
                    gm_gnt           = ~ren_req;
                    gm_err           = ~ren_req & sel_bad;
                end
            end else begin
                busy     = 1'b1;
                mem_cont = 1'b1;
                mem_addr = row_q;
                beat_col = cnt;
                rd_data  = bad_q ? 3'd0 : mem_rdata;
                if (own_gm) begin
                    gm_beat   = 1'b1;
                    gm_last   = (cnt == LAST_BEAT);
                    mem_wdata = we_q ? gm_wdata : 3'd0;
                end else begin
                    ren_beat = 1'b1;
                    ren_last = (cnt == LAST_BEAT);
                end
            end
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: behavioural board Memory, vector table, directed burst sequences and a randomized scoreboard.
module tb_board_mem_arbiter;
    localparam int COLS  = 10;
    localparam int ROW_W = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             ren_req = 1'b0;
    logic [ROW_W-1:0] ren_row = '0;
    logic             ren_gnt, ren_beat, ren_last;
    logic             gm_req = 1'b0;
    logic [ROW_W-1:0] gm_row = '0;
    logic             gm_we = 1'b0;
    logic [2:0]       gm_wdata;
    logic             gm_gnt, gm_beat, gm_last, gm_err;
    logic [2:0]       rd_data;
    logic [3:0]       beat_col;
    logic             busy, mem_start, mem_write_enable, mem_cont;
    logic [ROW_W-1:0] mem_addr;
    logic [2:0]       mem_wdata, mem_rdata;

    logic             wdata_follow = 1'b0;
    logic [2:0]       wdata_rand = 3'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign gm_wdata = wdata_follow ? beat_col[2:0] : wdata_rand;

    board_mem_arbiter #(.COLS(COLS), .ROW_W(ROW_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .ren_req(ren_req), .ren_row(ren_row), .ren_gnt(ren_gnt), .ren_beat(ren_beat), .ren_last(ren_last),
        .gm_req(gm_req), .gm_row(gm_row), .gm_we(gm_we), .gm_wdata(gm_wdata),
        .gm_gnt(gm_gnt), .gm_beat(gm_beat), .gm_last(gm_last), .gm_err(gm_err),
        .rd_data(rd_data), .beat_col(beat_col), .busy(busy),
        .mem_start(mem_start), .mem_write_enable(mem_write_enable), .mem_cont(mem_cont),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural board Memory: start latches row/we, each cont cycle is one cell.
    function automatic logic [2:0] init_val(input int r, input int c);
        return 3'((c + (r - 5) * 3) & 7);
    endfunction

    logic [2:0] env_mem [64][COLS];
    logic       env_init = 1'b0;
    logic [5:0] env_row = 6'd0;
    logic       env_we = 1'b0;
    int         env_idx = COLS;

    always @(posedge clk) begin
        if (!env_init) begin
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < COLS; c++)
                    env_mem[r][c] <= init_val(r, c);
            env_init <= 1'b1;
        end else if (mem_start) begin
            env_row <= mem_addr;
            env_we  <= mem_write_enable;
            env_idx <= 0;
        end else if (mem_cont) begin
            if (env_we && env_idx < COLS)
                env_mem[env_row][env_idx] <= mem_wdata;
            env_idx <= env_idx + 1;
        end
    end

    assign mem_rdata = (env_idx < COLS) ? env_mem[env_row][env_idx] : 3'd0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic render_read(input int row, input logic [2:0] exp [COLS], input string tag);
        to_next();
        ren_req = 1'b1;
        ren_row = 6'(row);
        #1;
        chk({tag, "_gnt"}, int'(ren_gnt), 1);
        chk({tag, "_start_addr"}, int'({mem_start, mem_addr}), 64 + row);
        to_next();
        ren_req = 1'b0;
        for (int k = 0; k < COLS; k++) begin
            @(negedge clk);
            chk({tag, "_rd_data"}, int'(rd_data), int'(exp[k]));
            chk({tag, "_beat_last_col"}, int'({ren_beat, ren_last, beat_col}), 32 + ((k == COLS - 1) ? 16 : 0) + k);
            to_next();
        end
        @(negedge clk);
        chk({tag, "_busy_after"}, int'({busy, ren_beat}), 0);
    endtask

    task automatic game_write(input int row, input int exp_we, input int exp_err, input string tag);
        to_next();
        wdata_follow = 1'b1;
        gm_req = 1'b1;
        gm_row = 6'(row);
        gm_we  = 1'b1;
        #1;
        chk({tag, "_gnt"}, int'({ren_gnt, gm_gnt}), 1);
        chk({tag, "_we"}, int'(mem_write_enable), exp_we);
        chk({tag, "_err"}, int'(gm_err), exp_err);
        to_next();
        gm_req = 1'b0;
        gm_we  = 1'b0;
        for (int k = 0; k < COLS; k++) begin
            @(negedge clk);
            chk({tag, "_beat_last_wdata"}, int'({gm_beat, gm_last, mem_wdata}),
                16 + ((k == COLS - 1) ? 8 : 0) + (k & 7));
            to_next();
        end
        wdata_follow = 1'b0;
    endtask

    typedef struct {
        logic       rr;
        logic [5:0] rrow;
        logic       gr;
        logic [5:0] grow;
        logic       gwe;
        logic       e_start;
        logic [5:0] e_addr;
        logic       e_we;
        logic       e_rgnt;
        logic       e_ggnt;
    } vec_t;

    vec_t vt [6];
    logic [2:0] exp_row [COLS];
    logic [2:0] ref_mem [64][COLS];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, gcyc, overlap, beats, rg_cyc, last_cyc;

        vt[0] = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b0, 1'b1, 6'd5,  1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 6'd0,  1'b1, 6'd9,  1'b1, 1'b1, 6'd9,  1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b0, 6'd0,  1'b1, 6'd9,  1'b0, 1'b1, 6'd9,  1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b1, 6'd12, 1'b1, 6'd9,  1'b1, 1'b1, 6'd12, 1'b0, 1'b1, 1'b0};
        vt[5] = '{1'b1, 6'd33, 1'b1, 6'd40, 1'b0, 1'b1, 6'd33, 1'b0, 1'b1, 1'b0};

        // Reset: outputs 0 even with a request applied
        #2 ren_req = 1'b1;
        ren_row = 6'd5;
        #1;
        chk("reset_outputs", int'({ren_gnt, ren_beat, ren_last, gm_gnt, gm_beat, gm_last, gm_err, busy,
                                  mem_start, mem_write_enable, mem_cont}), 0);
        chk("reset_data", int'({rd_data, beat_col, mem_addr, mem_wdata}), 0);
        ren_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Combinational arbitration in IDLE; requests dropped before the edge
        for (int i = 0; i < 6; i++) begin
            to_next();
            ren_req = vt[i].rr;  ren_row = vt[i].rrow;
            gm_req  = vt[i].gr;  gm_row  = vt[i].grow;  gm_we = vt[i].gwe;
            #1;
            chk($sformatf("vec%0d_start_addr", i), int'({mem_start, mem_addr}), int'({vt[i].e_start, vt[i].e_addr}));
            chk($sformatf("vec%0d_we_gnt", i), int'({mem_write_enable, ren_gnt, gm_gnt}),
                int'({vt[i].e_we, vt[i].e_rgnt, vt[i].e_ggnt}));
            ren_req = 1'b0;
            gm_req  = 1'b0;
            gm_we   = 1'b0;
        end
        to_next();
        #1;
        chk("dropped_req_idle", int'({busy, mem_cont, ren_beat, gm_beat}), 0);

        // Render read row 5 (preloaded 0..7,0,1)
        for (int c = 0; c < COLS; c++) exp_row[c] = 3'(c & 7);
        render_read(5, exp_row, "ren5");

        // Game write row 3 then render read it back
        game_write(3, 1, 0, "gw3");
        render_read(3, exp_row, "ren3");

        // Simultaneous requests: render first, game 11 cycles later
        to_next();
        ren_req = 1'b1; ren_row = 6'd5;
        gm_req  = 1'b1; gm_row  = 6'd6; gm_we = 1'b0;
        #1;
        chk("simul_first", int'({ren_gnt, gm_gnt}), 2);
        to_next();
        ren_req = 1'b0;
        found = 0; gcyc = -1; overlap = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            #1;
            if (ren_beat && gm_beat) overlap = 1;
            if (gm_gnt) begin
                found = 1;
                gcyc  = i;
            end else begin
                to_next();
            end
        end
        chk("simul_gm_gnt_delay", gcyc, 11);
        to_next();
        gm_req = 1'b0;
        for (int i = 0; i < COLS + 1; i++) begin
            #1;
            if (ren_beat && gm_beat) overlap = 1;
            to_next();
        end
        chk("simul_overlap", overlap, 0);

        // Render request during game beat 4 waits for game completion
        to_next();
        gm_req = 1'b1; gm_row = 6'd10; gm_we = 1'b0;
        #1;
        to_next();
        gm_req = 1'b0;
        beats = 0; rg_cyc = -1; last_cyc = -1;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (gm_beat) beats++;
            if (gm_beat && beat_col == 4'd4) begin
                ren_req = 1'b1;
                ren_row = 6'd11;
                #1;
            end
            if (gm_last) last_cyc = i;
            if (ren_gnt && rg_cyc < 0) rg_cyc = i;
            to_next();
            if (rg_cyc >= 0) ren_req = 1'b0;
        end
        chk("mid_game_beats", beats, COLS);
        chk("mid_ren_gnt_after_last", rg_cyc - last_cyc, 1);
        chk("mid_ren_gnt_cycle", rg_cyc, 10);

        // Reset during beat 6 of a game write on row 7
        to_next();
        wdata_follow = 1'b1;
        gm_req = 1'b1; gm_row = 6'd7; gm_we = 1'b1;
        to_next();
        gm_req = 1'b0; gm_we = 1'b0;
        for (int k = 0; k < 6; k++) to_next();
        #1;
        chk("pre_reset_beat6", int'({gm_beat, beat_col}), 16 + 6);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", int'({gm_beat, gm_last, busy, mem_cont, mem_start, mem_write_enable}), 0);
        chk("mid_reset_data", int'({rd_data, beat_col, mem_wdata, mem_addr}), 0);
        wdata_follow = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int c = 0; c < COLS; c++) exp_row[c] = (c < 6) ? 3'(c) : init_val(7, c);
        render_read(7, exp_row, "ren7_partial");

`ifdef BOARD_ROW_GUARD_EN
        game_write(25, 0, 1, "gw25_guard");
        for (int c = 0; c < COLS; c++) chk("row25_unchanged", int'(env_mem[25][c]), int'(init_val(25, c)));
        for (int c = 0; c < COLS; c++) exp_row[c] = 3'd0;
        render_read(55, exp_row, "ren55_guard");
`endif

        // Randomized traffic on rows 32..51 against a scoreboard of grant times and memory contents
        begin
            int  cyc, m_start, m_row, beat;
            bit  m_act, m_gm, m_we, ren_pend, gm_pend, drop_ren, drop_gm, e_rg, e_gg;
            cyc = 0; m_start = 0; m_row = 0; m_act = 0; m_gm = 0; m_we = 0;
            ren_pend = 0; gm_pend = 0; drop_ren = 0; drop_gm = 0;
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < COLS; c++)
                    ref_mem[r][c] = init_val(r, c);
            for (int n = 0; n < 1500; n++) begin
                to_next();
                cyc++;
                if (drop_ren) begin ren_req = 1'b0; ren_pend = 0; drop_ren = 0; end
                if (drop_gm)  begin gm_req = 1'b0; gm_we = 1'b0; gm_pend = 0; drop_gm = 0; end
                if (!ren_pend && $urandom_range(3) == 0) begin
                    ren_req = 1'b1; ren_row = 6'(32 + $urandom_range(19)); ren_pend = 1;
                end
                if (!gm_pend && $urandom_range(2) == 0) begin
                    gm_req = 1'b1; gm_row = 6'(32 + $urandom_range(19)); gm_we = 1'($urandom_range(1)); gm_pend = 1;
                end
                wdata_rand = 3'($urandom_range(7));
                @(negedge clk);
                if (m_act && cyc > m_start + COLS) m_act = 0;
                if (!m_act) begin
                    e_rg = ren_req;
                    e_gg = gm_req && !ren_req;
                    chk("rnd_idle_gnt", int'({ren_gnt, gm_gnt, mem_start}), int'({e_rg, e_gg, e_rg || e_gg}));
                    chk("rnd_idle_addr_we", int'({mem_addr, mem_write_enable}),
                        (e_rg ? int'(ren_row) : (e_gg ? int'(gm_row) : 0)) * 2 + int'(e_gg && gm_we));
                    chk("rnd_idle_quiet", int'({busy, mem_cont, ren_beat, gm_beat}), 0);
                    if (e_rg || e_gg) begin
                        m_act = 1; m_start = cyc; m_gm = e_gg;
                        m_row = e_gg ? int'(gm_row) : int'(ren_row);
                        m_we  = e_gg && gm_we;
                        if (e_rg) drop_ren = 1; else drop_gm = 1;
                    end
                end else begin
                    beat = cyc - m_start - 1;
                    chk("rnd_strobes", int'({busy, mem_cont, ren_beat, gm_beat, ren_last, gm_last, ren_gnt, gm_gnt}),
                        int'({1'b1, 1'b1, !m_gm, m_gm, !m_gm && beat == COLS - 1, m_gm && beat == COLS - 1, 2'b00}));
                    chk("rnd_beat_col", int'(beat_col), beat);
                    chk("rnd_rd_data", int'(rd_data), int'(ref_mem[m_row][beat]));
                    chk("rnd_mem_wdata", int'(mem_wdata), m_we ? int'(wdata_rand) : 0);
                    if (m_we) ref_mem[m_row][beat] = wdata_rand;
                end
            end
            to_next();
            ren_req = 1'b0;
            gm_req  = 1'b0;
            gm_we   = 1'b0;
            for (int i = 0; i < COLS + 2; i++) to_next();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
